// File: rtl/plab2_mem_secure_responder_pkg.sv
// Shared memory message definitions for the secure responder: request and
// response layouts, message type codes and the byte-count decode.
package plab2_mem_secure_responder_pkg;

  // Request message: {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
  typedef struct packed {
    logic [2:0]  mtype;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  // Response message: {type[2:0], opaque[7:0], len[1:0], data[31:0]}
  typedef struct packed {
    logic [2:0]  mtype;
    logic [7:0]  opaque;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

  localparam int MEM_REQ_NBITS  = $bits(mem_req_t);
  localparam int MEM_RESP_NBITS = $bits(mem_resp_t);

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  // len==0 encodes a full 4-byte word access
  function automatic logic [2:0] mem_nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/plab2_mem_resp_fifo.sv
// Two-entry response queue. Enqueue readiness depends only on occupancy, so a
// full queue never looks ready even if the consumer is dequeuing this cycle.
// The output message reads as zero whenever the queue is empty.
module plab2_mem_resp_fifo #(
  parameter int p_nbits = 45
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic [p_nbits-1:0] r_entry [2];
  logic               r_head;
  logic [1:0]         r_count;

  logic w_enq;
  logic w_deq;
  logic w_tail;

  assign enq_rdy = (r_count != 2'd2);
  assign deq_val = (r_count != 2'd0);
  assign deq_msg = deq_val ? r_entry[r_head] : '0;
  assign w_enq   = enq_val && enq_rdy;
  assign w_deq   = deq_val && deq_rdy;
  assign w_tail  = r_head ^ r_count[0];

  // Head pointer and occupancy; buffered entries are dropped on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_deq) r_head <= ~r_head;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (w_enq) r_entry[w_tail] <= enq_msg;
  end

endmodule

// File: rtl/plab2_mem_secure_responder.sv
// Secure memory responder: aligned reads/writes on a word array, with
// non-secure accesses to the secure window and malformed requests squashed
// and counted. Responses return one cycle after acceptance via a 2-entry queue.
module plab2_mem_secure_responder
  import plab2_mem_secure_responder_pkg::*;
#(
  parameter int          p_mem_nbytes = 4096,
  parameter logic [31:0] p_sec_lo     = 32'h0800,
  parameter logic [31:0] p_sec_hi     = 32'h0FFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      domain,
  input  logic [MEM_REQ_NBITS-1:0]  memreq_msg,
  input  logic                      memreq_val,
  output logic                      memreq_rdy,
  output logic [MEM_RESP_NBITS-1:0] memresp_msg,
  output logic                      memresp_val,
  input  logic                      memresp_rdy,
  output logic                      viol,
  output logic [7:0]                viol_count
);

  localparam int c_nwords = p_mem_nbytes / 4;
  localparam int c_idx_w  = $clog2(c_nwords);

  logic [31:0] r_mem [c_nwords];
  logic        r_viol;
  logic [7:0]  r_viol_count;

  mem_req_t             w_req;
  mem_resp_t            w_resp;
  logic [2:0]           w_nbytes;
  logic [3:0]           w_off4;
  logic [3:0]           w_nb4;
  logic                 w_aligned;
  logic                 w_in_range;
  logic [32:0]          w_last;
  logic                 w_sec_hit;
  logic                 w_bad_type;
  logic                 w_viol;
  logic                 w_accept;
  logic                 w_enq_rdy;
  logic                 w_is_read;
  logic                 w_is_write;
  logic [c_idx_w-1:0]   w_idx;
  logic [31:0]          w_word;
  logic [4:0]           w_shamt;
  logic [31:0]          w_word_shift;
  logic [31:0]          w_wdata_shift;
  logic [31:0]          w_rd_data;
  logic [31:0]          w_wr_word;

  assign w_req      = mem_req_t'(memreq_msg);
  assign w_nbytes   = mem_nbytes(w_req.len);
  assign w_off4     = {2'b00, w_req.addr[1:0]};
  assign w_nb4      = {1'b0, w_nbytes};
  assign w_aligned  = (w_off4 + w_nb4) <= 4'd4;
  assign w_in_range = ({1'b0, w_req.addr} < 33'(p_mem_nbytes));
  // Last byte touched, kept at 33 bits so addresses near the top cannot wrap
  assign w_last     = {1'b0, w_req.addr} + {30'd0, w_nbytes} - 33'd1;
  assign w_sec_hit  = ({1'b0, w_req.addr} <= {1'b0, p_sec_hi}) &&
                      (w_last >= {1'b0, p_sec_lo});
  assign w_bad_type = (w_req.mtype != MEM_TYPE_READ) && (w_req.mtype != MEM_TYPE_WRITE);
  assign w_viol     = w_bad_type || !w_aligned || !w_in_range || (w_sec_hit && !domain);

  assign memreq_rdy = reset && w_enq_rdy;
  assign w_accept   = memreq_val && memreq_rdy;
  assign w_is_read  = !w_viol && (w_req.mtype == MEM_TYPE_READ);
  assign w_is_write = !w_viol && (w_req.mtype == MEM_TYPE_WRITE);

  assign w_idx         = w_req.addr[c_idx_w+1:2];
  assign w_word        = r_mem[w_idx];
  assign w_shamt       = {w_req.addr[1:0], 3'b000};
  assign w_word_shift  = w_word >> w_shamt;
  assign w_wdata_shift = w_req.data << w_shamt;

  // Byte-lane extract (right-aligned, zero-extended) and write merge
  always_comb begin
    w_rd_data = '0;
    w_wr_word = w_word;
    for (int b = 0; b < 4; b++) begin
      if (4'(b) < w_nb4)
        w_rd_data[8*b +: 8] = w_word_shift[8*b +: 8];
      if ((4'(b) >= w_off4) && (4'(b) < (w_off4 + w_nb4)))
        w_wr_word[8*b +: 8] = w_wdata_shift[8*b +: 8];
    end
  end

  // Response echoes type/opaque/len; data is zero unless a clean read
  always_comb begin
    w_resp        = '0;
    w_resp.mtype  = w_req.mtype;
    w_resp.opaque = w_req.opaque;
    w_resp.len    = w_req.len;
    w_resp.data   = w_is_read ? w_rd_data : 32'd0;
  end

  // Word array update for accepted, non-violating writes
  always_ff @(posedge clk) begin
    if (w_accept && w_is_write) r_mem[w_idx] <= w_wr_word;
  end

  // Violation pulse and saturating violation counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_viol       <= 1'b0;
      r_viol_count <= 8'd0;
    end else begin
      r_viol <= w_accept && w_viol;
      if (w_accept && w_viol && (r_viol_count != 8'hFF))
        r_viol_count <= r_viol_count + 8'd1;
    end
  end

  assign viol       = r_viol;
  assign viol_count = r_viol_count;

  plab2_mem_resp_fifo #(
    .p_nbits (MEM_RESP_NBITS)
  ) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_val (w_accept),
    .enq_rdy (w_enq_rdy),
    .enq_msg (w_resp),
    .deq_val (memresp_val),
    .deq_rdy (memresp_rdy),
    .deq_msg (memresp_msg)
  );

endmodule
